// File: rtl/fifo_rd_packer_if.sv
// Signal bundle between the FWFT FIFO read port, the packer and the wide output stream.
// The packer is the master: it drives the pop strobe, the output beat and the error flag.
interface fifo_rd_packer_if #(
    parameter int IN_WIDTH = 32,
    parameter int PACK_NUM = 4
);
    logic                         fifo_empty;
    logic [IN_WIDTH-1:0]          fifo_rdata;
    logic                         fifo_err;
    logic                         fifo_ren;
    logic                         flush;
    logic                         m_valid;
    logic [IN_WIDTH*PACK_NUM-1:0] m_data;
    logic [PACK_NUM-1:0]          m_keep;
    logic                         m_ready;
    logic                         err;

    modport master (
        input  fifo_empty, fifo_rdata, fifo_err, flush, m_ready,
        output fifo_ren, m_valid, m_data, m_keep, err
    );

    modport slave (
        output fifo_empty, fifo_rdata, fifo_err, flush, m_ready,
        input  fifo_ren, m_valid, m_data, m_keep, err
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK_NUM narrow FWFT FIFO words into one wide registered beat, with
// partial beats on flush or idle timeout and a sticky FIFO ECC error flag.
// Handshake: a beat transfers on a clk edge where m_valid && m_ready; while m_valid
// is high and m_ready low, m_data and m_keep hold. A word is popped on an edge where fifo_ren is high.
module fifo_rd_packer #(
    parameter int IN_WIDTH      = 32,
    parameter int PACK_NUM      = 4,
    parameter int FLUSH_TIMEOUT = 64,
    parameter int TO_CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_rd_packer_if.master     bus,
    output logic [1:0]           dbg_state
);
    localparam int CNT_W = $clog2(PACK_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_NUM);
    localparam bit TO_EN = (FLUSH_TIMEOUT != 0);
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
        TO_EN ? TO_CNT_WIDTH'(FLUSH_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} state_e;

    state_e                             state;
    logic [PACK_NUM-1:0][IN_WIDTH-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]                   acc_cnt, cnt_nxt;
    logic                               flush_pend, fp_nxt;
    logic [TO_CNT_WIDTH-1:0]            idle_cnt, idle_nxt;
    logic                               m_valid_q, valid_nxt;
    logic [PACK_NUM-1:0][IN_WIDTH-1:0]  m_data_q, data_nxt, beat_data;
    logic [PACK_NUM-1:0]                m_keep_q, keep_nxt, beat_keep;
    logic                               err_q, err_nxt;
    logic                               out_free, move, pop, idle_inc, to_hit, flush_set;

    always_comb begin
        state     = ST_FILL;
        out_free  = 1'b0;
        move      = 1'b0;
        pop       = 1'b0;
        idle_inc  = 1'b0;
        to_hit    = 1'b0;
        flush_set = 1'b0;
        acc_nxt   = acc;
        cnt_nxt   = acc_cnt;
        idle_nxt  = idle_cnt;
        valid_nxt = m_valid_q;
        data_nxt  = m_data_q;
        keep_nxt  = m_keep_q;
        beat_data = '0;
        beat_keep = '0;
        err_nxt   = err_q | bus.fifo_err;

        if (acc_cnt == '0)          state = ST_EMPTY;
        else if (acc_cnt == CNT_FULL) state = ST_FULL;

        out_free = !m_valid_q || bus.m_ready;
        move     = out_free && (state == ST_FULL || (flush_pend && state != ST_EMPTY));
        pop      = rst_n && !bus.fifo_empty && !flush_pend && (state != ST_FULL || move);

        // Only filled lanes reach the output; the rest are forced to zero.
        for (int i = 0; i < PACK_NUM; i++) begin
            if (CNT_W'(i) < acc_cnt) begin
                beat_keep[i] = 1'b1;
                beat_data[i] = acc[i];
            end
        end

        if (move) begin
            cnt_nxt = pop ? CNT_W'(1) : '0;
            if (pop) acc_nxt[0] = bus.fifo_rdata;
        end else if (pop) begin
            for (int i = 0; i < PACK_NUM; i++) begin
                if (CNT_W'(i) == acc_cnt) acc_nxt[i] = bus.fifo_rdata;
            end
            cnt_nxt = acc_cnt + 1'b1;
        end

        if (move) begin
            valid_nxt = 1'b1;
            data_nxt  = beat_data;
            keep_nxt  = beat_keep;
        end else if (m_valid_q && bus.m_ready) begin
            valid_nxt = 1'b0;
        end

        idle_inc = TO_EN && state == ST_FILL && !pop && !flush_pend;
        to_hit   = idle_inc && idle_cnt == TO_LAST;
        if (pop || move || state != ST_FILL) idle_nxt = '0;
        else if (to_hit)                     idle_nxt = '0;
        else if (idle_inc)                   idle_nxt = idle_cnt + 1'b1;

        // A flush landing on a move cycle only matters if a word enters the fresh beat.
        flush_set = bus.flush && (move ? pop : (state != ST_EMPTY || pop));
        fp_nxt    = flush_set || to_hit || (flush_pend && !move);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            idle_cnt   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            acc_cnt    <= cnt_nxt;
            flush_pend <= fp_nxt;
            idle_cnt   <= idle_nxt;
            m_valid_q  <= valid_nxt;
            m_data_q   <= data_nxt;
            m_keep_q   <= keep_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.fifo_ren = pop;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_keep   = m_keep_q;
    assign bus.err      = err_q;
    assign dbg_state    = state;
endmodule
